// File: rtl/hms_timekeeper.sv
// hms_timekeeper: 24-hour H:M:S clock with a RUN / SET_H / SET_M button-driven setting FSM.
// Ports: clk, rst (async, active-high); mode_btn, inc_btn (clean, clk-synchronous buttons);
//        H/M/S (binary time); sec_tick (one-cycle pulse per RUN step); set_mode (00 RUN, 01 SET_H, 10 SET_M).
module hms_timekeeper #(
  parameter int TICK_DIV = 50000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mode_btn,
  input  logic       inc_btn,
  output logic [6:0] H,
  output logic [6:0] M,
  output logic [6:0] S,
  output logic       sec_tick,
  output logic [1:0] set_mode
);
  localparam logic [1:0] RUN = 2'b00, SET_H = 2'b01, SET_M = 2'b10;
  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);
  logic [CW-1:0] cnt;
  logic mode_q, inc_q, mode_edge, inc_edge, run, step, s_wrap, m_wrap;
  // btn_q registers reset to 1 so a button held through reset release gives no edge
  assign mode_edge = mode_btn & ~mode_q;
  assign inc_edge  = inc_btn & ~inc_q & ~mode_edge;
  assign run       = set_mode == RUN;
  assign step      = run && cnt == LAST;
  assign s_wrap    = S == 7'd59;
  assign m_wrap    = M == 7'd59;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      mode_q   <= 1'b1;
      inc_q    <= 1'b1;
      cnt      <= '0;
      sec_tick <= 1'b0;
      set_mode <= RUN;
      H        <= 7'd0;
      M        <= 7'd0;
      S        <= 7'd0;
    end else begin
      mode_q   <= mode_btn;
      inc_q    <= inc_btn;
      sec_tick <= step;
      // prescaler only advances while staying in RUN; every other path parks it at 0
      cnt      <= (run && !mode_edge && !step) ? cnt + 1'b1 : '0;
      set_mode <= !mode_edge ? set_mode : run ? SET_H : set_mode == SET_H ? SET_M : RUN;
      if (step) begin
        S <= s_wrap ? 7'd0 : S + 7'd1;
        M <= !s_wrap ? M : m_wrap ? 7'd0 : M + 7'd1;
        H <= !(s_wrap && m_wrap) ? H : H == 7'd23 ? 7'd0 : H + 7'd1;
      end else if (set_mode == SET_H && inc_edge)
        H <= H == 7'd23 ? 7'd0 : H + 7'd1;
      else if (set_mode == SET_M && mode_edge)
        S <= 7'd0;
      else if (set_mode == SET_M && inc_edge)
        M <= m_wrap ? 7'd0 : M + 7'd1;
    end
endmodule

// File: tb/tb_hms_timekeeper.sv
// tb_hms_timekeeper: scoreboard bench for hms_timekeeper with TICK_DIV=4.
module tb_hms_timekeeper;
  logic clk, rst, mode_btn, inc_btn, sec_tick;
  logic [6:0] H, M, S;
  logic [1:0] set_mode;
  logic [23:0] obs;
  typedef struct {string tag; logic [23:0] v;} exp_t;
  exp_t q[$];
  int n_chk, n_fail, eh, em, es, emd, tot;
  hms_timekeeper #(.TICK_DIV(4)) dut (
    .clk(clk), .rst(rst), .mode_btn(mode_btn), .inc_btn(inc_btn),
    .H(H), .M(M), .S(S), .sec_tick(sec_tick), .set_mode(set_mode)
  );
  assign obs = {H, M, S, sec_tick, set_mode};
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [23:0] got, input logic [23:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got H=%0d M=%0d S=%0d tick=%0b mode=%0d, want H=%0d M=%0d S=%0d tick=%0b mode=%0d",
               tag, got[23:17], got[16:10], got[9:3], got[2], got[1:0],
               want[23:17], want[16:10], want[9:3], want[2], want[1:0]);
    end
  endtask
  function automatic logic [23:0] pk(input int h, m, s, input logic t, input int md);
    return {7'(h), 7'(m), 7'(s), t, 2'(md)};
  endfunction
  task automatic cyc(input logic mb, input logic ib, input logic t, input string tag);
    exp_t e;
    e.tag = tag;
    e.v = pk(eh, em, es, t, emd);
    q.push_back(e);
    mode_btn = mb;
    inc_btn = ib;
    @(posedge clk);
    #4;
  endtask
  always @(posedge clk) begin
    #2;
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      check(e.tag, obs, e.v);
    end
  end
  initial begin
    n_chk = 0; n_fail = 0;
    rst = 1'b1; mode_btn = 1'b0; inc_btn = 1'b0;
    repeat (2) @(posedge clk);
    #4;
    check("reset", obs, pk(0, 0, 0, 0, 0));
    rst = 1'b0;
    eh = 0; em = 0; es = 0; emd = 0;
    for (int c = 1; c <= 12; c++) begin es = c / 4; cyc(0, 0, c % 4 == 0, "run12"); end
    emd = 1; cyc(1, 0, 0, "to_set_h");
    for (int i = 1; i <= 25; i++) begin eh = i % 24; cyc(0, 1, 0, "inc_h"); cyc(0, 0, 0, "rel_h"); end
    emd = 2; cyc(1, 0, 0, "to_set_m");
    for (int i = 1; i <= 61; i++) begin em = i % 60; cyc(0, 1, 0, "inc_m"); cyc(0, 0, 0, "rel_m"); end
    em = 2;
    for (int i = 0; i < 10; i++) cyc(0, 1, 0, "hold_inc");
    cyc(0, 0, 0, "rel_hold");
    emd = 0; es = 0; cyc(1, 0, 0, "to_run_clear_s");
    for (int c = 1; c <= 4; c++) begin es = c / 4; cyc(0, 0, c == 4, "first_step"); end
    emd = 1; cyc(1, 0, 0, "to_set_h2"); cyc(0, 0, 0, "rel");
    emd = 2; cyc(1, 1, 0, "mode_inc_same"); cyc(0, 0, 0, "rel");
    for (int i = 3; i <= 59; i++) begin em = i; cyc(0, 1, 0, "preset_m"); cyc(0, 0, 0, "rel_m"); end
    emd = 0; es = 0; cyc(1, 0, 0, "to_run2"); cyc(0, 0, 0, "rel");
    emd = 1; cyc(1, 0, 0, "to_set_h3");
    for (int i = 2; i <= 23; i++) begin eh = i; cyc(0, 1, 0, "preset_h"); cyc(0, 0, 0, "rel_h"); end
    emd = 2; cyc(1, 0, 0, "to_set_m3"); cyc(0, 0, 0, "rel");
    emd = 0; cyc(1, 0, 0, "to_run3");
    for (int c = 1; c <= 240; c++) begin
      tot = (23 * 3600 + 59 * 60 + c / 4) % 86400;
      eh = tot / 3600; em = (tot / 60) % 60; es = tot % 60;
      cyc(0, logic'(c % 2), c % 4 == 0, "rollover");
    end
    for (int c = 1; c <= 3; c++) cyc(0, 0, 0, "pre_coinc");
    es = 1; emd = 1; cyc(1, 0, 1, "step_and_mode"); cyc(0, 0, 0, "rel");
    for (int i = 1; i <= 12; i++) begin eh = i; cyc(0, 1, 0, "set12"); cyc(0, 0, 0, "rel"); end
    emd = 2; cyc(1, 0, 0, "to_set_m4"); cyc(0, 0, 0, "rel");
    for (int i = 1; i <= 34; i++) begin em = i; cyc(0, 1, 0, "set34"); cyc(0, 0, 0, "rel"); end
    emd = 0; es = 0; cyc(1, 0, 0, "to_run4");
    for (int c = 1; c <= 224; c++) begin es = c / 4; cyc(0, 0, c % 4 == 0, "run56"); end
    emd = 1; cyc(1, 0, 0, "set_h_keeps_s"); cyc(0, 0, 0, "rel");
    emd = 2; cyc(1, 0, 0, "to_set_m5"); cyc(0, 0, 0, "rel");
    check("preset_123456", obs, pk(12, 34, 56, 0, 2));
    #2;
    mode_btn = 1'b1;
    rst = 1'b1;
    #1;
    check("async_rst", obs, pk(0, 0, 0, 0, 0));
    @(posedge clk);
    #4;
    rst = 1'b0;
    eh = 0; em = 0; es = 0; emd = 0;
    for (int c = 1; c <= 8; c++) begin es = c / 4; cyc(1, 0, c % 4 == 0, "mode_held_rst"); end
    @(posedge clk);
    #4;
    check("sb_drain", 24'(q.size()), 24'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
